// File: rtl/uart_rx_deserializer.sv
// UART receive deframer: 16x-oversampled RX line to LSB-aligned words with error strobes.
// Optional break detection (break_o) is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_baud_tick_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_i,
  input  logic [1:0] parity_mode_i,
  input  logic       fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_error_o,
  output logic       parity_error_o,
  output logic       overrun_error_o,
  output logic       rx_idle_o
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic       break_o
`endif
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // XOR-reduction of the data word together with the received parity bit
  function automatic logic parity_of(input logic [7:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_prev_r;
  logic                   rx_sync_s;
  logic                   fall_s;

  state_e                 state_r;
  logic [TICK_W-1:0]      tick_cnt_r;
  logic [2:0]             bit_cnt_r;
  logic                   stop_cnt_r;
  logic [7:0]             data_r;
  logic [1:0]             dw_r;
  logic                   two_stop_r;
  logic [1:0]             pmode_r;
  logic                   frame_err_r;
  logic                   par_err_r;
  logic                   stop_err_s;
  logic [2:0]             last_bit_s;
  logic                   mid_s;
  logic                   end_s;

  logic [7:0]             rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_error_r;
  logic                   parity_error_r;
  logic                   overrun_error_r;
  logic                   rx_idle_r;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                   par_bit_r;
  logic                   break_r;
`endif

  assign rx_sync_s  = sync_r[SYNC_STAGES-1];
  assign fall_s     = rx_prev_r & ~rx_sync_s;
  assign mid_s      = ov_baud_tick_i & (tick_cnt_r == HALF_LAST);
  assign end_s      = ov_baud_tick_i & (tick_cnt_r == FULL_LAST);
  assign last_bit_s = {1'b0, dw_r} + 3'd4;
  assign stop_err_s = frame_err_r | ~rx_sync_s;

  // Metastability synchronizer and previous-sample register for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], rx_i};
      rx_prev_r <= rx_sync_s;
    end
  end

  // Receive FSM with registered output strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r         <= ST_IDLE;
      tick_cnt_r      <= '0;
      bit_cnt_r       <= 3'd0;
      stop_cnt_r      <= 1'b0;
      data_r          <= 8'h00;
      dw_r            <= 2'b00;
      two_stop_r      <= 1'b0;
      pmode_r         <= 2'b00;
      frame_err_r     <= 1'b0;
      par_err_r       <= 1'b0;
      rx_data_r       <= 8'h00;
      rx_valid_r      <= 1'b0;
      frame_error_r   <= 1'b0;
      parity_error_r  <= 1'b0;
      overrun_error_r <= 1'b0;
      rx_idle_r       <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_r       <= 1'b0;
      break_r         <= 1'b0;
`endif
    end else begin
      rx_valid_r      <= 1'b0;
      frame_error_r   <= 1'b0;
      parity_error_r  <= 1'b0;
      overrun_error_r <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_r         <= 1'b0;
`endif
      if (!rx_enable_i) begin
        state_r   <= ST_IDLE;
        rx_idle_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (fall_s) begin
              // a tick coinciding with the edge is already the first START tick
              state_r    <= ST_START;
              rx_idle_r  <= 1'b0;
              tick_cnt_r <= ov_baud_tick_i ? TICK_W'(1) : TICK_W'(0);
            end
          end
          ST_START: begin
            if (mid_s) begin
              tick_cnt_r <= '0;
              if (!rx_sync_s) begin
                state_r     <= ST_DATA;
                dw_r        <= data_width_i;
                two_stop_r  <= (stop_bits_i == 2'b01);
                pmode_r     <= parity_mode_i;
                data_r      <= 8'h00;
                bit_cnt_r   <= 3'd0;
                stop_cnt_r  <= 1'b0;
                frame_err_r <= 1'b0;
                par_err_r   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                par_bit_r   <= 1'b0;
`endif
              end else begin
                state_r   <= ST_IDLE;
                rx_idle_r <= 1'b1;
              end
            end else if (ov_baud_tick_i) begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          ST_DATA: begin
            if (end_s) begin
              tick_cnt_r        <= '0;
              data_r[bit_cnt_r] <= rx_sync_s;
              if (bit_cnt_r == last_bit_s) begin
                state_r <= pmode_r[1] ? ST_STOP : ST_PARITY;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end else if (ov_baud_tick_i) begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          ST_PARITY: begin
            if (end_s) begin
              tick_cnt_r <= '0;
              par_err_r  <= (parity_of(data_r, rx_sync_s) != pmode_r[0]);
`ifdef UART_RX_BREAK_DETECT_EN
              par_bit_r  <= rx_sync_s;
`endif
              state_r    <= ST_STOP;
            end else if (ov_baud_tick_i) begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          ST_STOP: begin
            if (end_s) begin
              tick_cnt_r <= '0;
              if (two_stop_r && !stop_cnt_r) begin
                stop_cnt_r  <= 1'b1;
                frame_err_r <= stop_err_s;
              end else begin
                // completion happens at the last stop mid-bit, not at bit end
                state_r   <= ST_IDLE;
                rx_idle_r <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                if ((data_r == 8'h00) && !par_bit_r && !rx_sync_s) begin
                  break_r <= 1'b1;
                end else begin
`else
                begin
`endif
                  frame_error_r  <= stop_err_s;
                  parity_error_r <= par_err_r;
                  if (fifo_full_i) begin
                    overrun_error_r <= 1'b1;
                  end else begin
                    rx_valid_r <= 1'b1;
                    rx_data_r  <= data_r;
                  end
                end
              end
            end else if (ov_baud_tick_i) begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            rx_idle_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rx_data_o       = rx_data_r;
  assign rx_valid_o      = rx_valid_r;
  assign frame_error_o   = frame_error_r;
  assign parity_error_o  = parity_error_r;
  assign overrun_error_o = overrun_error_r;
  assign rx_idle_o       = rx_idle_r;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_o         = break_r;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer (16x oversampling, tick every 2 clocks).
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic       rx_enable;
  logic [1:0] data_width;
  logic [1:0] stop_bits;
  logic [1:0] parity_mode;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       overrun_error;
  logic       rx_idle;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk;
`endif

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_frame = 0, n_par = 0, n_ovr = 0, n_brk = 0;
  int b_valid, b_frame, b_par, b_ovr, b_brk;

  uart_rx_deserializer #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ov_baud_tick_i (tick),
    .rx_i           (rx),
    .rx_enable_i    (rx_enable),
    .data_width_i   (data_width),
    .stop_bits_i    (stop_bits),
    .parity_mode_i  (parity_mode),
    .fifo_full_i    (fifo_full),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .frame_error_o  (frame_error),
    .parity_error_o (parity_error),
    .overrun_error_o(overrun_error),
    .rx_idle_o      (rx_idle)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_o        (brk)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  end

  // pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) n_valid++;
    if (frame_error === 1'b1) n_frame++;
    if (parity_error === 1'b1) n_par++;
    if (overrun_error === 1'b1) n_ovr++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (brk === 1'b1) n_brk++;
`endif
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_frame = n_frame; b_par = n_par; b_ovr = n_ovr; b_brk = n_brk;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one bit = 16 ticks = 32 clocks
  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(32);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input int npar,
                            input logic pbit, input int nstop, input logic sval);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (npar != 0) send_bit(pbit);
    for (int i = 0; i < nstop; i++) send_bit(sval);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_enable = 1'b1; fifo_full = 1'b0;
    data_width = 2'b11; stop_bits = 2'b00; parity_mode = 2'b10;
    wait_clks(3);
    check("reset_idle", 32'(rx_idle), 32'd1);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_ferr", 32'(frame_error), 32'd0);
    check("reset_perr", 32'(parity_error), 32'd0);
    check("reset_oerr", 32'(overrun_error), 32'd0);
    rst = 1'b0;
    wait_clks(40);

    // 8N1 0xA5
    snap();
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    rx = 1'b1; wait_clks(64);
    check("t1_valid", 32'(n_valid - b_valid), 32'd1);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_errs", 32'(n_frame - b_frame + n_par - b_par + n_ovr - b_ovr), 32'd0);
    check("t1_idle", 32'(rx_idle), 32'd1);

    // 7-bit ODD, 2 stop: 0x41 has two ones, so parity bit 0 is wrong
    data_width = 2'b10; parity_mode = 2'b01; stop_bits = 2'b01;
    snap();
    send_frame(8'h41, 7, 1, 1'b0, 2, 1'b1);
    rx = 1'b1; wait_clks(64);
    check("t2_valid", 32'(n_valid - b_valid), 32'd1);
    check("t2_data", 32'(rx_data), 32'h41);
    check("t2_perr", 32'(n_par - b_par), 32'd1);
    check("t2_ferr", 32'(n_frame - b_frame), 32'd0);

    // 8N1 0x3C with stop bit 0, then line low 3 more bit times
    data_width = 2'b11; parity_mode = 2'b10; stop_bits = 2'b00;
    snap();
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b0);
    rx = 1'b0; wait_clks(96);
    rx = 1'b1; wait_clks(96);
    check("t3_valid", 32'(n_valid - b_valid), 32'd1);
    check("t3_data", 32'(rx_data), 32'h3C);
    check("t3_ferr", 32'(n_frame - b_frame), 32'd1);
    check("t3_perr", 32'(n_par - b_par), 32'd0);

    // 5-bit EVEN 0x15 (three ones) with parity 1: correct
    data_width = 2'b00; parity_mode = 2'b00;
    snap();
    send_frame(8'h15, 5, 1, 1'b1, 1, 1'b1);
    rx = 1'b1; wait_clks(64);
    check("t4_valid", 32'(n_valid - b_valid), 32'd1);
    check("t4_data", 32'(rx_data), 32'h15);
    check("t4_errs", 32'(n_frame - b_frame + n_par - b_par), 32'd0);
    // glitch of 4 ticks is rejected at the start-bit mid sample
    snap();
    rx = 1'b0; wait_clks(8);
    rx = 1'b1; wait_clks(96);
    check("t4_glitch_valid", 32'(n_valid - b_valid), 32'd0);
    check("t4_glitch_idle", 32'(rx_idle), 32'd1);

    // overrun: FIFO full at completion, data discarded
    data_width = 2'b11; parity_mode = 2'b11;
    fifo_full = 1'b1;
    snap();
    send_frame(8'h77, 8, 0, 1'b0, 1, 1'b1);
    rx = 1'b1; wait_clks(64);
    check("t5_valid", 32'(n_valid - b_valid), 32'd0);
    check("t5_ovr", 32'(n_ovr - b_ovr), 32'd1);
    check("t5_data_kept", 32'(rx_data), 32'h15);
    fifo_full = 1'b0;
    snap();
    send_frame(8'h12, 8, 0, 1'b0, 1, 1'b1);
    rx = 1'b1; wait_clks(64);
    check("t5b_valid", 32'(n_valid - b_valid), 32'd1);
    check("t5b_data", 32'(rx_data), 32'h12);
    check("t5b_ovr", 32'(n_ovr - b_ovr), 32'd0);

    // enable dropped in the middle of DATA
    snap();
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t6_busy", 32'(rx_idle), 32'd0);
    rx_enable = 1'b0;
    wait_clks(1);
    check("t6_idle_next", 32'(rx_idle), 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1);
    wait_clks(32);
    rx_enable = 1'b1;
    wait_clks(64);
    check("t6_pulses", 32'(n_valid - b_valid + n_frame - b_frame + n_par - b_par + n_ovr - b_ovr),
          32'd0);

    // 12 bit-times low on an 8N1 line
    snap();
    rx = 1'b0; wait_clks(12 * 32);
    rx = 1'b1; wait_clks(96);
`ifdef UART_RX_BREAK_DETECT_EN
    check("brk_pulse", 32'(n_brk - b_brk), 32'd1);
    check("brk_valid", 32'(n_valid - b_valid), 32'd0);
    check("brk_ferr", 32'(n_frame - b_frame), 32'd0);
`else
    check("zero_valid", 32'(n_valid - b_valid), 32'd1);
    check("zero_data", 32'(rx_data), 32'h00);
    check("zero_ferr", 32'(n_frame - b_frame), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
